// File: rtl/icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_fill_ctrl
// Description : Instruction-cache fill controller. Accepts instruction words
//               from a valid/ready source and writes each one into byte-wide
//               cache storage, lowest byte at the lowest address.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_fill_ctrl #(
  parameter int MEM_WIDTH   = 8,
  parameter int INSTR_WIDTH = 32,
  parameter int CACHE_SIZE  = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8:0]             fill_len,
  input  logic                   src_valid,
  input  logic [INSTR_WIDTH-1:0] src_data,
  output logic                   src_ready,
  output logic                   wr_en,
  output logic [9:0]             wr_addr,
  output logic [MEM_WIDTH-1:0]   wr_byte,
  output logic                   busy,
  output logic                   fetch_stall,
  output logic                   done,
  output logic                   err
);

  localparam int C_BPW    = INSTR_WIDTH / MEM_WIDTH;
  localparam int C_BIDX_W = (C_BPW > 1) ? $clog2(C_BPW) : 1;
  localparam logic [C_BIDX_W-1:0] C_LAST_K  = C_BIDX_W'(C_BPW - 1);
  localparam logic [8:0]          C_MAX_LEN = 9'(CACHE_SIZE);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_WORD = 2'd1,
    S_WRITE     = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t                  r_state;
  logic [8:0]              r_len;
  logic [8:0]              r_word_idx;
  logic [C_BIDX_W-1:0]     r_byte_idx;
  logic [9:0]              r_byte_addr;   // running 4*word_index + k
  logic [INSTR_WIDTH-1:0]  r_word;        // remaining bytes, next byte in the low lane
  logic [8:0]              w_word_idx_inc;

  assign w_word_idx_inc = r_word_idx + 9'd1;

  // The fetch pipeline is held for exactly as long as a fill is in flight.
  assign fetch_stall = busy;

  // Fill sequencer: state, indices and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_word_idx  <= '0;
      r_byte_idx  <= '0;
      r_byte_addr <= '0;
      r_word      <= '0;
      src_ready   <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_byte     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (fill_len == 9'd0) begin
              // Empty fill completes immediately without touching storage.
              err     <= 1'b0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else if (fill_len > C_MAX_LEN) begin
              // Over-length request is rejected; flag stays set until a new start.
              err     <= 1'b1;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              err         <= 1'b0;
              r_len       <= fill_len;
              r_word_idx  <= '0;
              r_byte_idx  <= '0;
              r_byte_addr <= '0;
              src_ready   <= 1'b1;
              r_state     <= S_WAIT_WORD;
            end
          end
        end

        S_WAIT_WORD: begin
          if (src_valid) begin
            // Byte 0 goes out straight from the source; the rest is kept shifted.
            src_ready   <= 1'b0;
            r_word      <= src_data >> MEM_WIDTH;
            wr_en       <= 1'b1;
            wr_addr     <= r_byte_addr;
            wr_byte     <= src_data[MEM_WIDTH-1:0];
            r_byte_addr <= r_byte_addr + 10'd1;
            r_byte_idx  <= '0;
            r_state     <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (r_byte_idx == C_LAST_K) begin
            r_word_idx <= w_word_idx_inc;
            r_byte_idx <= '0;
            if (w_word_idx_inc == r_len) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              src_ready <= 1'b1;
              r_state   <= S_WAIT_WORD;
            end
          end else begin
            r_byte_idx  <= r_byte_idx + 1'b1;
            wr_en       <= 1'b1;
            wr_addr     <= r_byte_addr;
            wr_byte     <= r_word[MEM_WIDTH-1:0];
            r_word      <= r_word >> MEM_WIDTH;
            r_byte_addr <= r_byte_addr + 10'd1;
          end
        end

        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          busy      <= 1'b0;
          src_ready <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_fill_ctrl
// Description : Scoreboard bench for icache_fill_ctrl. Stimulus pushes the
//               expected write/done events; a monitor pops and compares them
//               whenever the controller writes a byte or pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_fill_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  fill_len;
  logic        src_valid;
  logic [31:0] src_data;
  logic        src_ready;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [7:0]  wr_byte;
  logic        busy;
  logic        fetch_stall;
  logic        done;
  logic        err;

  typedef struct packed {
    logic       is_done;
    logic       after_wr;
    logic [9:0] addr;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] src_words[$];
  int          src_rd;
  int          n_checks;
  int          n_errors;
  int          cyc;
  int          last_wr_cyc;
  logic [9:0]  last_wr_addr;

  icache_fill_ctrl #(
    .MEM_WIDTH  (8),
    .INSTR_WIDTH(32),
    .CACHE_SIZE (256)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .fill_len   (fill_len),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_byte    (wr_byte),
    .busy       (busy),
    .fetch_stall(fetch_stall),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_wr(input logic [9:0] a, input logic [7:0] d);
    exp_t e;
    e = '0;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endfunction

  function automatic void push_word(input logic [9:0] base, input logic [31:0] w);
    for (int k = 0; k < 4; k++) push_wr(base + 10'(k), w[8*k +: 8]);
  endfunction

  function automatic void push_done(input logic e_err, input logic after_wr);
    exp_t e;
    e = '0;
    e.is_done  = 1'b1;
    e.after_wr = after_wr;
    e.err      = e_err;
    sb_q.push_back(e);
  endfunction

  task automatic issue_start(input logic [8:0] len);
    start    = 1'b1;
    fill_len = len;
    @(posedge clk); #1;
    start    = 1'b0;
    fill_len = 9'd0;
  endtask

  // Latency is counted in clock edges after the edge that sampled start.
  task automatic wait_done(input string name, input int exp_lat, input int bound);
    int n;
    bit seen;
    bit stall_ok;
    n = 0;
    seen = 1'b0;
    stall_ok = 1'b1;
    while (!seen && n < bound) begin
      @(negedge clk);
      n++;
      if (busy !== 1'b1 || fetch_stall !== 1'b1) stall_ok = 1'b0;
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    if (seen && exp_lat >= 0) chk({name, "_latency"}, n - 1, exp_lat);
    chk({name, "_busy_stall"}, 32'(stall_ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_src_ready"},   32'(src_ready),   32'd0);
    chk({pfx, "_wr_en"},       32'(wr_en),       32'd0);
    chk({pfx, "_wr_addr"},     32'(wr_addr),     32'd0);
    chk({pfx, "_wr_byte"},     32'(wr_byte),     32'd0);
    chk({pfx, "_busy"},        32'(busy),        32'd0);
    chk({pfx, "_fetch_stall"}, 32'(fetch_stall), 32'd0);
    chk({pfx, "_done"},        32'(done),        32'd0);
    chk({pfx, "_err"},         32'(err),         32'd0);
  endtask

  // Source model: presents queued words; a word is consumed on an accepting edge.
  initial begin
    src_rd    = 0;
    src_valid = 1'b0;
    src_data  = '0;
    forever begin
      @(posedge clk);
      if (rst) src_rd = src_words.size();
      else if (src_valid && src_ready) src_rd++;
      #2;
      src_valid = (src_rd < src_words.size());
      src_data  = src_valid ? src_words[src_rd] : 32'd0;
    end
  end

  // Monitor: pops one expected event per observed write or done pulse.
  initial begin
    exp_t e;
    cyc          = 0;
    last_wr_cyc  = -100;
    last_wr_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        chk("stall_eq_busy", 32'(fetch_stall), 32'(busy));
        if (wr_en) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write actual addr=%0d byte=0x%0h expected no write", wr_addr, wr_byte);
          end else begin
            e = sb_q.pop_front();
            chk("event_is_write", 32'(e.is_done), 32'd0);
            chk("wr_addr", 32'(wr_addr), 32'(e.addr));
            chk("wr_byte", 32'(wr_byte), 32'(e.data));
          end
          last_wr_cyc  = cyc;
          last_wr_addr = wr_addr;
        end
        if (done) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done actual done=1 expected no done");
          end else begin
            e = sb_q.pop_front();
            chk("event_is_done", 32'(e.is_done), 32'd1);
            chk("done_err", 32'(err), 32'(e.err));
            if (e.after_wr) chk("done_gap", cyc - last_wr_cyc, 32'd1);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    start    = 1'b0;
    fill_len = 9'd0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Two words, continuous source.
    push_wr(10'd0, 8'h44); push_wr(10'd1, 8'h33); push_wr(10'd2, 8'h22); push_wr(10'd3, 8'h11);
    push_wr(10'd4, 8'hDD); push_wr(10'd5, 8'hCC); push_wr(10'd6, 8'hBB); push_wr(10'd7, 8'hAA);
    push_done(1'b0, 1'b1);
    src_words.push_back(32'h11223344);
    src_words.push_back(32'hAABBCCDD);
    issue_start(9'd2);
    wait_done("fill2", 10, 2000);

    // One word after the source idles for six cycles.
    push_wr(10'd0, 8'hEF); push_wr(10'd1, 8'hBE); push_wr(10'd2, 8'hAD); push_wr(10'd3, 8'hDE);
    push_done(1'b0, 1'b1);
    issue_start(9'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("wait_src_ready", 32'(src_ready), 32'd1);
      chk("wait_no_write", 32'(wr_en), 32'd0);
      @(posedge clk); #1;
    end
    src_words.push_back(32'hDEADBEEF);
    wait_done("fill1_wait", -1, 200);

    // Zero length and over-length requests.
    push_done(1'b0, 1'b0);
    issue_start(9'd0);
    wait_done("len0", 0, 50);
    chk("len0_err", 32'(err), 32'd0);
    push_done(1'b1, 1'b0);
    issue_start(9'd257);
    wait_done("len257", 0, 50);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", 32'(err), 32'd1);
    push_wr(10'd0, 8'h04); push_wr(10'd1, 8'h03); push_wr(10'd2, 8'h02); push_wr(10'd3, 8'h01);
    push_done(1'b0, 1'b1);
    src_words.push_back(32'h01020304);
    issue_start(9'd1);
    chk("err_cleared", 32'(err), 32'd0);
    wait_done("fill_after_err", 5, 200);

    // Full-capacity fill.
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = (32'(i) * 32'h01010101) ^ 32'h5A3C0F96;
      src_words.push_back(w);
      push_word(10'(4 * i), w);
    end
    push_done(1'b0, 1'b1);
    issue_start(9'd256);
    wait_done("fill256", 1280, 2000);
    chk("fill256_last_addr", 32'(last_wr_addr), 32'd1023);

    // Reset during byte 2 of word 3.
    for (int i = 0; i < 5; i++) begin
      logic [31:0] w;
      w = 32'h10203040 + 32'(i) * 32'h01010101;
      src_words.push_back(w);
      if (i < 3) push_word(10'(4 * i), w);
    end
    push_wr(10'd12, 8'h43);
    push_wr(10'd13, 8'h33);
    issue_start(9'd5);
    repeat (18) @(posedge clk);
    #1;
    chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
    chk("pre_rst_addr", 32'(wr_addr), 32'd14);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_events_drained", sb_q.size(), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_idle_busy", 32'(busy), 32'd0);
    push_wr(10'd0, 8'h0D); push_wr(10'd1, 8'hF0); push_wr(10'd2, 8'hFE); push_wr(10'd3, 8'hCA);
    push_done(1'b0, 1'b1);
    src_words.push_back(32'hCAFEF00D);
    issue_start(9'd1);
    wait_done("refill", 5, 200);

    // Second start while waiting for a word must be ignored.
    push_wr(10'd0, 8'h88); push_wr(10'd1, 8'h77); push_wr(10'd2, 8'h66); push_wr(10'd3, 8'h55);
    push_wr(10'd4, 8'hCC); push_wr(10'd5, 8'hBB); push_wr(10'd6, 8'hAA); push_wr(10'd7, 8'h99);
    push_done(1'b0, 1'b1);
    issue_start(9'd2);
    @(posedge clk); #1;
    start    = 1'b1;
    fill_len = 9'd1;
    @(posedge clk); #1;
    start    = 1'b0;
    fill_len = 9'd0;
    chk("restart_still_waiting", 32'(src_ready), 32'd1);
    src_words.push_back(32'h55667788);
    src_words.push_back(32'h99AABBCC);
    wait_done("restart_ignored", -1, 300);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
